// File: rtl/hci_stream_downsizer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | hci_stream_downsizer                                               |
// | Splits wide stream words into RATIO narrow beats, stops at tot_len. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hci_stream_downsizer #(
    parameter int IN_DW = 128,
    parameter int RATIO = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic                   req_start_i,
    input  logic [CNT_W-1:0]       tot_len_i,
    output logic                   ready_start_o,
    output logic                   done_o,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [IN_DW-1:0]       in_data_i,
    input  logic [IN_DW/8-1:0]     in_strb_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [IN_DW/RATIO-1:0] out_data_o,
    output logic [IN_DW/RATIO/8-1:0] out_strb_o
);

    localparam int OUT_DW = IN_DW / RATIO;
    localparam int OUT_BW = OUT_DW / 8;
    localparam int IDX_W  = $clog2(RATIO);

    generate
        if ((IN_DW % (8 * RATIO)) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_params
            $error("hci_stream_downsizer: IN_DW must split into whole bytes and RATIO must be a power of 2 >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tot_len_q, tot_len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_DW-1:0]   data_q, data_d;
    logic [IN_DW/8-1:0] strb_q, strb_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic w_run, w_last_slice, w_zero_len, w_final_cnt;
    logic w_out_hs, w_final_hs, w_in_hs;

    logic [OUT_DW-1:0] w_data_slice [RATIO];
    logic [OUT_BW-1:0] w_strb_slice [RATIO];

    // Slice 0 is the least significant part of the held word.
    generate
        for (genvar g = 0; g < RATIO; g++) begin : g_slice
            assign w_data_slice[g] = data_q[g*OUT_DW +: OUT_DW];
            assign w_strb_slice[g] = strb_q[g*OUT_BW +: OUT_BW];
        end
    endgenerate

    assign out_data_o = w_data_slice[idx_q];
    assign out_strb_o = w_strb_slice[idx_q];

    always_comb begin
        w_run         = (state_q == RUN);
        w_last_slice  = (idx_q == IDX_W'(RATIO - 1));
        w_zero_len    = (tot_len_q == '0);
        w_final_cnt   = (cnt_q == tot_len_q - CNT_W'(1));
        ready_start_o = ~w_run;
        out_valid_o   = w_run & enable_i & valid_q;
        w_out_hs      = out_valid_o & out_ready_i;
        w_final_hs    = w_out_hs & w_final_cnt;
        // A new word may land in the same cycle the last slice leaves, unless that beat ends the transfer.
        in_ready_o    = w_run & enable_i & ~w_zero_len & ~w_final_hs
                        & (~valid_q | (w_out_hs & w_last_slice));
        w_in_hs       = in_valid_i & in_ready_o;
        done_o        = w_run & enable_i & (w_zero_len | w_final_hs);

        state_d   = state_q;
        tot_len_d = tot_len_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        strb_d    = strb_q;
        valid_d   = valid_q;
        idx_d     = idx_q;

        if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (req_start_i) begin
                        state_d   = RUN;
                        tot_len_d = tot_len_i;
                        cnt_d     = '0;
                        valid_d   = 1'b0;
                        idx_d     = '0;
                    end
                end
                RUN: begin
                    if (done_o) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        if (w_out_hs) begin
                            idx_d = idx_q + IDX_W'(1);
                            cnt_d = cnt_q + CNT_W'(1);
                            if (w_last_slice) begin
                                valid_d = 1'b0;
                            end
                        end
                        if (w_in_hs) begin
                            data_d  = in_data_i;
                            strb_d  = in_strb_i;
                            valid_d = 1'b1;
                            idx_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q   <= IDLE;
            tot_len_q <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            tot_len_q <= tot_len_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hci_stream_downsizer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hci_stream_downsizer                                            |
// | Cycle tables for directed cases, queue model for random streams.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_hci_stream_downsizer;

    localparam int IN_DW = 128;
    localparam int RATIO = 4;
    localparam int CNT_W = 16;

    localparam logic [127:0] WA = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] WB = 128'h77777777_66666666_55555555_44444444;
    localparam logic [15:0]  SA = 16'h8421;
    localparam logic [15:0]  SB = 16'h0F3C;

    logic         clk = 1'b0;
    logic         rst, clear, en, start;
    logic [15:0]  tot_len;
    logic         iv, ordy;
    logic [127:0] idata;
    logic [15:0]  istrb;
    logic         ready_start, done, in_ready, out_valid;
    logic [31:0]  out_data;
    logic [3:0]   out_strb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hci_stream_downsizer #(.IN_DW(IN_DW), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(en),
        .req_start_i(start), .tot_len_i(tot_len),
        .ready_start_o(ready_start), .done_o(done),
        .in_valid_i(iv), .in_ready_o(in_ready),
        .in_data_i(idata), .in_strb_i(istrb),
        .out_valid_o(out_valid), .out_ready_i(ordy),
        .out_data_o(out_data), .out_strb_o(out_strb)
    );

    typedef struct {
        bit          en, st, cl, rs, iv, ordy;
        logic [15:0] len;
        bit          w;
        bit          ers, eir, eov, edn, cd;
        logic [31:0] ed;
        logic [3:0]  es;
    } row_t;

    row_t tbl[$];

    task automatic chk(input string nm, input int id, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    // Directed beats carry nibble k replicated across the 32-bit beat.
    function automatic logic [31:0] bd(input int k);
        logic [3:0] n;
        n = 4'(k);
        return {8{n}};
    endfunction

    function automatic int bs(input int k);
        logic [15:0] s;
        s = (k < 4) ? SA : SB;
        return int'(s[(k % 4) * 4 +: 4]);
    endfunction

    task automatic add(input int e, st, cl, rs, v, r, len, w, ers, eir, eov, edn, cd,
                       input logic [31:0] ed, input int es);
        row_t x;
        x.en = (e != 0); x.st = (st != 0); x.cl = (cl != 0); x.rs = (rs != 0);
        x.iv = (v != 0); x.ordy = (r != 0); x.len = 16'(len); x.w = (w != 0);
        x.ers = (ers != 0); x.eir = (eir != 0); x.eov = (eov != 0); x.edn = (edn != 0);
        x.cd = (cd != 0); x.ed = ed; x.es = 4'(es);
        tbl.push_back(x);
    endtask

    // Beat rows hold req_start high: it must be ignored while running.
    task automatic beat(input int w, input int k, input int eir, input int edn);
        add(1, 1, 0, 0, 1, 1, 3, w, 0, eir, 1, edn, 1, bd(k), bs(k));
    endtask

    task automatic run_txn(input int len, input bit rnd);
        logic [127:0] wq[$];
        logic [15:0]  sq[$];
        logic [31:0]  ed[$];
        logic [3:0]   es[$];
        logic [127:0] w;
        logic [15:0]  s;
        logic [31:0]  pd;
        logic [3:0]   ps;
        int nw, wi, bi, cyc;
        bit fin, pst, hs;
        nw = (len + RATIO - 1) / RATIO;
        for (int i = 0; i <= nw; i++) begin
            wq.push_back({$urandom, $urandom, $urandom, $urandom});
            sq.push_back(16'($urandom));
        end
        for (int k = 0; k < len; k++) begin
            w = wq[k / RATIO];
            s = sq[k / RATIO];
            ed.push_back(w[(k % RATIO) * 32 +: 32]);
            es.push_back(s[(k % RATIO) * 4 +: 4]);
        end
        @(negedge clk);
        en = 1'b1; start = 1'b1; tot_len = 16'(len); iv = 1'b0; ordy = 1'b0;
        #1 chk("txn_start_ready", len, ready_start, 1);
        wi = 0; bi = 0; fin = 0; pst = 0; cyc = 0; pd = '0; ps = '0;
        while (!fin && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            tot_len = 16'($urandom);
            en      = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            ordy    = rnd ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
            iv      = (wi <= nw) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            idata   = (wi <= nw) ? wq[wi] : '0;
            istrb   = (wi <= nw) ? sq[wi] : '0;
            #1;
            if (pst && out_valid) begin
                chk("stall_data", bi, out_data, pd);
                chk("stall_strb", bi, out_strb, ps);
            end
            pst = out_valid && !ordy;
            pd  = out_data;
            ps  = out_strb;
            hs  = out_valid && ordy;
            if (hs) begin
                if (bi < len) begin
                    chk("beat_data", bi, out_data, ed[bi]);
                    chk("beat_strb", bi, out_strb, es[bi]);
                end else begin
                    chk("extra_beat", bi, 1, 0);
                end
            end
            chk("txn_done", bi, done, hs && (bi == len - 1));
            if (hs) begin
                if (bi == len - 1) fin = 1;
                bi++;
            end
            if (iv && in_ready) wi++;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout len=%0d: got %0d beats expected %0d", len, bi, len);
        end
        chk("txn_beats", len, bi, len);
        chk("txn_words", len, wi, nw);
        @(negedge clk);
        en = 1'b1; ordy = 1'b0; iv = 1'b0;
        #1;
        chk("txn_idle_ready", len, ready_start, 1);
        chk("txn_idle_valid", len, out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; en = 1'b0; start = 1'b0; tot_len = '0;
        iv = 1'b0; ordy = 1'b0; idata = '0; istrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready_start", 0, ready_start, 1);
        chk("rst_done", 0, done, 0);
        chk("rst_in_ready", 0, in_ready, 0);
        chk("rst_out_valid", 0, out_valid, 0);
        chk("rst_out_data", 0, out_data, 0);
        chk("rst_out_strb", 0, out_strb, 0);

        // Eight beats from two words at full rate.
        add(1, 1, 0, 0, 1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) beat(1, k, (k == 3) ? 1 : 0, (k == 7) ? 1 : 0);
        add(1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);

        // Length 6: last two slices of the second word are dropped.
        add(1, 1, 0, 0, 1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) beat(1, k, (k == 3) ? 1 : 0, (k == 5) ? 1 : 0);
        add(1, 0, 0, 0, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0);

        // Zero length completes without touching the input.
        add(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);

        // Clear at beat 3, then a clean length-4 run.
        add(1, 1, 0, 0, 1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) beat(1, k, 0, 0);
        add(1, 1, 1, 0, 0, 1, 3, 1, 0, 1, 1, 0, 1, bd(3), bs(3));
        add(1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 1, 4, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) beat(0, k, 0, (k == 3) ? 1 : 0);
        add(1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);

        // Start blocked while disabled; five disabled cycles mid-word.
        add(0, 1, 0, 0, 1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        beat(1, 0, 0, 0);
        beat(1, 1, 0, 0);
        for (int c = 0; c < 5; c++) add(0, 1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 1, bd(2), bs(2));
        for (int k = 2; k < 8; k++) beat(1, k, (k == 3) ? 1 : 0, (k == 7) ? 1 : 0);
        add(1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset mid-run drops the word.
        add(1, 1, 0, 0, 1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1, 3, 1, 0, 0, 1, 0, 1, bd(0), bs(0));
        add(1, 0, 0, 0, 1, 1, 3, 1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 1, 1, 0, 0, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            en = tbl[i].en; start = tbl[i].st; clear = tbl[i].cl; rst = tbl[i].rs;
            iv = tbl[i].iv; ordy = tbl[i].ordy; tot_len = tbl[i].len;
            idata = tbl[i].w ? WB : WA;
            istrb = tbl[i].w ? SB : SA;
            #1;
            chk("ready_start", i, ready_start, tbl[i].ers);
            chk("in_ready", i, in_ready, tbl[i].eir);
            chk("out_valid", i, out_valid, tbl[i].eov);
            chk("done", i, done, tbl[i].edn);
            if (tbl[i].cd) begin
                chk("out_data", i, out_data, tbl[i].ed);
                chk("out_strb", i, out_strb, tbl[i].es);
            end
        end
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; start = 1'b0; iv = 1'b0;

        run_txn(8, 1'b0);
        for (int t = 0; t < 25; t++) run_txn($urandom_range(1, 13), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hci_stream_downsizer.md
HCI_STREAM_DOWNSIZER -- requirements
Module: hci_stream_downsizer

Interface
REQ-001 SHALL have parameter IN_DW, default 128: input stream data width in bits, a multiple of 8.
REQ-002 SHALL have parameter RATIO, default 4: input-to-output width ratio, a power of 2, at least 2.
REQ-003 SHALL have parameter CNT_W, default 16: width of the beat counter and of tot_len.
REQ-004 SHALL derive OUT_DW = IN_DW/RATIO; IN_DW not divisible into whole bytes per beat is illegal (elaboration assert).
REQ-005 SHALL have one clock and a synchronous, active-high reset; the clock port is clk_i and the reset port is rst_i.
REQ-006 clk_i  in  1  clock; all state updates on its rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 clear_i  in  1  synchronous soft clear, same effect as rst_i.
REQ-009 enable_i  in  1  global enable; when 0 all state freezes.
REQ-010 req_start_i  in  1  start request, sampled in IDLE.
REQ-011 tot_len_i  in  CNT_W  number of output beats to emit, latched on start.
REQ-012 ready_start_o  out  1  1 while in IDLE.
REQ-013 done_o  out  1  one-cycle pulse on the final output handshake.
REQ-014 in_valid_i / in_ready_o  in / out  1 / 1  wide stream handshake from the upstream load streamer.
REQ-015 in_data_i / in_strb_i  in  IN_DW / IN_DW/8  wide word and byte strobes.
REQ-016 out_valid_o / out_ready_i  out / in  1 / 1  narrow stream handshake.
REQ-017 out_data_o / out_strb_o  out  OUT_DW / OUT_DW/8  narrow beat and its strobe slice.

Function
REQ-018 SHALL implement FSM states IDLE and RUN.
REQ-019 IDLE: in_ready_o=0, out_valid_o=0; on enable_i & req_start_i SHALL latch tot_len_i, clear the counter, go RUN.
REQ-020 If the latched tot_len is 0, the block SHALL pulse done_o in the first RUN cycle and return to IDLE without accepting input.
REQ-021 RUN SHALL hold one wide word in a register (data_q, strb_q, valid_q) with slice index idx_q (log2 RATIO bits).
REQ-022 Input accept SHALL be registered: a word accepted in cycle t gives out_valid_o=1 in t+1 with idx_q=0.
REQ-023 out_valid_o SHALL equal enable_i & valid_q in RUN; out_data_o/out_strb_o SHALL be slice idx_q, slice 0 = LSBs.
REQ-024 An output handshake SHALL increment idx_q and the beat counter; at idx_q=RATIO-1 it wraps to 0 and valid_q clears unless a new word is accepted in the same cycle.
REQ-025 in_ready_o SHALL equal RUN & enable_i & (~valid_q | (out handshake & idx_q=RATIO-1)) & not final beat, giving sustained one output beat per cycle.
REQ-026 Output data and strobe SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-027 On the output handshake where counter=tot_len-1, done_o=1 in that cycle; next state IDLE; valid_q and idx_q clear, discarding remaining slices.
REQ-028 The counter SHALL be CNT_W bits and SHALL NOT wrap in normal use (tot_len max 2^CNT_W-1).
REQ-029 enable_i=0 SHALL force in_ready_o=0, out_valid_o=0, done_o=0 and hold all registers.
REQ-030 req_start_i in RUN SHALL be ignored.

Reset
REQ-031 rst_i or clear_i SHALL, next edge, set state IDLE, valid_q=0, idx_q=0, counter=0, tot_len register=0, data_q/strb_q=0; rst_i has priority.
REQ-032 After reset: ready_start_o=1, done_o=0, in_ready_o=0, out_valid_o=0, out_data_o=0, out_strb_o=0.
REQ-033 Reset or clear mid-RUN SHALL drop the held word without emitting further beats or done_o.

Verification
REQ-034 IN_DW=128, RATIO=4, tot_len=8, words 0x33..33_22..22_11..11_00..00 then 0x77.._44.., out_ready=1 -> beats 0x0..,0x1..,...,0x7.. on consecutive cycles, in_ready high every 4th cycle, done_o with beat 8.
REQ-035 tot_len=6, two words -> beats 0..5 emitted, slices 6/7 discarded, done_o on beat 6, ready_start_o=1 next cycle.
REQ-036 out_ready_i toggling 1/0 -> each beat held stable while stalled, no beat lost or duplicated, 8 beats total.
REQ-037 tot_len=0, req_start -> done_o pulses one cycle later, no input accepted.
REQ-038 clear_i at beat 3 of 8 -> IDLE next cycle, out_valid_o=0, no done_o; new start with tot_len=4 completes normally.
REQ-039 enable_i=0 for 5 cycles mid-word -> no handshakes, idx_q and counter frozen, resumes at same slice.
